// File: rtl/wt_dcache_mem_req_buf.sv
// Purpose : decouples the write-through dcache memory port from the memory adapter.
//           Queues requests in a small FIFO, caps in-flight transactions and holds
//           non-cacheable loads until all earlier traffic has returned.
// Latency : 1 cycle minimum from req_ack_o to out_vld_o (registered storage, no bypass).
// Backpr. : req_ack_o is withheld while the FIFO is full; out_* holds the head entry
//           until out_rdy_i, and issue stalls at MaxOutstanding or on a blocked NC load.
// Ports   : clk_i/rst_ni (sync, active-low); req_* from dcache (vld held until ack);
//           out_* valid/ready toward the adapter; rtrn_vld_i = one completed return;
//           idle_o = nothing queued or outstanding; err_o = sticky return underflow.
module wt_dcache_mem_req_buf #(
  parameter int unsigned Depth          = 4,
  parameter int unsigned PlenWidth      = 56,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_vld_i,
  output logic                 req_ack_o,
  input  logic [1:0]           req_type_i,
  input  logic                 req_nc_i,
  input  logic [2:0]           req_size_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  input  logic [PlenWidth-1:0] req_paddr_i,
  input  logic [63:0]          req_data_i,
  output logic                 out_vld_o,
  input  logic                 out_rdy_i,
  output logic [1:0]           out_type_o,
  output logic                 out_nc_o,
  output logic [2:0]           out_size_o,
  output logic [TidWidth-1:0]  out_tid_o,
  output logic [PlenWidth-1:0] out_paddr_o,
  output logic [63:0]          out_data_o,
  input  logic                 rtrn_vld_i,
  output logic                 idle_o,
  output logic                 err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [1:0]  TypeLoad = 2'd0;

  typedef struct packed {
    logic [1:0]           typ;
    logic                 nc;
    logic [2:0]           size;
    logic [TidWidth-1:0]  tid;
    logic [PlenWidth-1:0] paddr;
    logic [63:0]          data;
  } entry_t;

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic            err_q, err_d;

  entry_t head;
  logic   full, empty, nc_block, push, issue;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (fifo_cnt_q == (PtrW+1)'(Depth));
  assign empty = (fifo_cnt_q == '0);

  // An NC load must observe every earlier transaction complete, so it only
  // leaves the head once the outstanding count has drained to zero.
  assign nc_block = (head.typ == TypeLoad) && head.nc && (out_cnt_q != '0);

  // Outputs are forced quiet while reset is held so the adapter and cache
  // never see a handshake from stale state before the reset edge.
  assign req_ack_o = rst_ni & req_vld_i & ~full;
  assign out_vld_o = rst_ni & ~empty & (out_cnt_q < CntW'(MaxOutstanding)) & ~nc_block;
  assign idle_o    = ~rst_ni | (empty & (out_cnt_q == '0));
  assign err_o     = err_q;

  assign push  = req_ack_o;
  assign issue = out_vld_o & out_rdy_i;

  assign out_type_o  = head.typ;
  assign out_nc_o    = head.nc;
  assign out_size_o  = head.size;
  assign out_tid_o   = head.tid;
  assign out_paddr_o = head.paddr;
  assign out_data_o  = head.data;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    out_cnt_d  = out_cnt_q;
    err_d      = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{typ:   req_type_i,
                          nc:    req_nc_i,
                          size:  req_size_i,
                          tid:   req_tid_i,
                          paddr: req_paddr_i,
                          data:  req_data_i};
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, issue})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (PtrW+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (PtrW+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // A return paired with an issue nets to zero even at count 0; only an
    // unpaired return against an empty count is an underflow.
    case ({issue, rtrn_vld_i})
      2'b10: out_cnt_d = out_cnt_q + CntW'(1);
      2'b01: begin
        if (out_cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          out_cnt_d = out_cnt_q - CntW'(1);
        end
      end
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
    end
  end

  // Payload storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_wt_dcache_mem_req_buf.sv
module tb_wt_dcache_mem_req_buf;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;

  typedef struct {
    logic [1:0]  typ;
    logic        nc;
    logic [2:0]  size;
    logic [1:0]  tid;
    logic [55:0] paddr;
    logic [63:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_ack;
  logic [1:0]  req_type = '0;
  logic        req_nc = 1'b0;
  logic [2:0]  req_size = '0;
  logic [1:0]  req_tid = '0;
  logic [55:0] req_paddr = '0;
  logic [63:0] req_data = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [1:0]  out_type;
  logic        out_nc;
  logic [2:0]  out_size;
  logic [1:0]  out_tid;
  logic [55:0] out_paddr;
  logic [63:0] out_data;
  logic        rtrn = 1'b0;
  logic        idle;
  logic        err;

  wt_dcache_mem_req_buf #(
    .Depth(DEPTH), .PlenWidth(56), .TidWidth(2), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_vld_i(req_vld), .req_ack_o(req_ack),
    .req_type_i(req_type), .req_nc_i(req_nc), .req_size_i(req_size),
    .req_tid_i(req_tid), .req_paddr_i(req_paddr), .req_data_i(req_data),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy),
    .out_type_o(out_type), .out_nc_o(out_nc), .out_size_o(out_size),
    .out_tid_o(out_tid), .out_paddr_o(out_paddr), .out_data_o(out_data),
    .rtrn_vld_i(rtrn), .idle_o(idle), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: accepted-but-not-issued requests in order, plus a plain
  // integer of issued-but-unreturned transactions and a sticky error bit.
  req_t m_q[$];
  int   m_out = 0;
  bit   m_err = 1'b0;
  bit   started = 1'b0;
  bit   exp_ack = 1'b0;
  bit   exp_vld = 1'b0;
  bit   exp_idle = 1'b1;
  bit   ack_smp = 1'b0;

  req_t stim_q[$];
  bit   auto_rtrn = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: predicts this cycle's handshake outputs from the model and
  // compares the issued head against the oldest queued request.
  always @(negedge clk) begin
    ack_smp = req_ack;
    if (started) begin
      exp_ack  = rst_n && req_vld && (m_q.size() < DEPTH);
      exp_vld  = rst_n && (m_q.size() > 0) && (m_out < MAXO) &&
                 !(m_q[0].typ == 2'd0 && m_q[0].nc && m_out != 0);
      exp_idle = !rst_n || (m_q.size() == 0 && m_out == 0);
      cmp("req_ack", 64'(req_ack), 64'(exp_ack));
      cmp("out_vld", 64'(out_vld), 64'(exp_vld));
      cmp("idle",    64'(idle),    64'(exp_idle));
      cmp("err",     64'(err),     64'(m_err));
      if (out_vld && out_rdy && exp_vld) begin
        cmp("out_type",  64'(out_type),  64'(m_q[0].typ));
        cmp("out_nc",    64'(out_nc),    64'(m_q[0].nc));
        cmp("out_size",  64'(out_size),  64'(m_q[0].size));
        cmp("out_tid",   64'(out_tid),   64'(m_q[0].tid));
        cmp("out_paddr", 64'(out_paddr), 64'(m_q[0].paddr));
        cmp("out_data",  out_data,       m_q[0].data);
      end
    end
  end

  req_t cur;
  bit   iss;
  always @(posedge clk) begin
    cur = '{typ: req_type, nc: req_nc, size: req_size, tid: req_tid,
            paddr: req_paddr, data: req_data};
    if (!rst_n) begin
      m_q.delete();
      m_out = 0;
      m_err = 1'b0;
    end else begin
      iss = exp_vld && out_rdy;
      if (iss) m_q.delete(0);
      if (exp_ack) m_q.push_back(cur);
      if (iss && !rtrn) m_out++;
      else if (!iss && rtrn) begin
        if (m_out == 0) m_err = 1'b1;
        else m_out--;
      end
    end
    started = 1'b1;
  end

  // One clock of stimulus: releases an acked request, presents the next one
  // from the stimulus queue, and generates returns when in auto mode.
  task automatic tick();
    req_t r;
    @(posedge clk);
    #1;
    if (req_vld && ack_smp) req_vld = 1'b0;
    if (!req_vld && stim_q.size() > 0) begin
      r = stim_q.pop_front();
      req_type = r.typ; req_nc = r.nc; req_size = r.size;
      req_tid = r.tid; req_paddr = r.paddr; req_data = r.data;
      req_vld = 1'b1;
    end
    rtrn = auto_rtrn && (m_out > 0) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_req(input logic [1:0] typ, input logic nc, input logic [2:0] size,
                          input logic [1:0] tid, input logic [55:0] paddr,
                          input logic [63:0] data);
    stim_q.push_back('{typ: typ, nc: nc, size: size, tid: tid, paddr: paddr, data: data});
  endtask

  task automatic push_rand();
    logic [63:0] a;
    a = {$urandom(), $urandom()};
    push_req(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), a[55:0],
             {$urandom(), $urandom()});
  endtask

  task automatic drain();
    int budget;
    auto_rtrn = 1'b1;
    out_rdy = 1'b1;
    budget = 0;
    while (!(stim_q.size() == 0 && !req_vld && m_q.size() == 0 && m_out == 0) && budget < 500) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (budget >= 500) begin
      n_err++;
      $display("FAIL drain_timeout: queued=%0d outstanding=%0d, required 0/0", m_q.size(), m_out);
    end
    auto_rtrn = 1'b0;
    tick();
  endtask

  task automatic rtrn_pulse();
    rtrn = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    tick();

    // Single store round trip.
    out_rdy = 1'b1;
    push_req(2'd1, 1'b0, 3'd3, 2'd1, 56'h80001000, 64'hDEADBEEF);
    tick();
    tick();
    @(negedge clk);
    cmp("p1_vld", 64'(out_vld), 64'd1);
    cmp("p1_busy", 64'(idle), 64'd0);
    tick();
    rtrn_pulse();
    @(negedge clk);
    cmp("p1_idle", 64'(idle), 64'd1);

    // Full FIFO backpressure and ordering across the pointer wrap.
    drain();
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++)
      push_req(2'd1, 1'b0, 3'd3, 2'(i), 56'(64'h1000 + 64'(i) * 8), 64'(i) + 64'hA0);
    wait_cycles(9);
    @(negedge clk);
    cmp("p2_full_vld", 64'(req_vld), 64'd1);
    cmp("p2_full_ack", 64'(req_ack), 64'd0);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    wait_cycles(4);
    drain();

    // Outstanding cap.
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++)
      push_req(2'd1, 1'b0, 3'd2, 2'(i), 56'(64'h2000 + 64'(i) * 8), 64'(i));
    wait_cycles(12);
    rtrn_pulse();
    wait_cycles(3);
    drain();

    // NC load serialised behind two cacheable loads; store waits behind it.
    out_rdy = 1'b1;
    push_req(2'd0, 1'b0, 3'd3, 2'd0, 56'h3000, 64'd0);
    push_req(2'd0, 1'b0, 3'd3, 2'd1, 56'h3008, 64'd0);
    push_req(2'd0, 1'b1, 3'd2, 2'd2, 56'h4000, 64'd0);
    push_req(2'd1, 1'b0, 3'd3, 2'd3, 56'h3010, 64'h55);
    wait_cycles(8);
    rtrn_pulse();
    wait_cycles(3);
    rtrn_pulse();
    wait_cycles(4);
    drain();

    // Underflow error, then simultaneous issue + return at count 2.
    rtrn_pulse();
    wait_cycles(3);
    push_req(2'd1, 1'b0, 3'd3, 2'd0, 56'h5000, 64'd1);
    push_req(2'd2, 1'b0, 3'd3, 2'd1, 56'h5008, 64'd2);
    out_rdy = 1'b1;
    wait_cycles(5);
    out_rdy = 1'b0;
    push_req(2'd3, 1'b0, 3'd3, 2'd2, 56'h5010, 64'd3);
    wait_cycles(3);
    out_rdy = 1'b1;
    rtrn_pulse();
    out_rdy = 1'b0;
    wait_cycles(2);

    // Reset with queued and outstanding work.
    for (int i = 0; i < 3; i++)
      push_req(2'd1, 1'b0, 3'd3, 2'(i), 56'(64'h6000 + 64'(i) * 8), 64'(i));
    wait_cycles(6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    cmp("p6_idle", 64'(idle), 64'd1);
    cmp("p6_vld", 64'(out_vld), 64'd0);
    cmp("p6_err", 64'(err), 64'd0);
    push_req(2'd1, 1'b0, 3'd3, 2'd3, 56'h7000, 64'h77);
    tick();
    @(negedge clk);
    cmp("p6_ack", 64'(req_ack), 64'd1);
    drain();

    // Randomised traffic with occasional resets.
    auto_rtrn = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      if (stim_q.size() == 0 && $urandom_range(0, 1) == 0) push_rand();
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wt_dcache_mem_req_buf.md
Name: wt_dcache_mem_req_buf

Overview:
Decoupling stage directly downstream of the write-through dcache memory port. It accepts the cache's request/ack transactions into a small FIFO and issues them to the memory adapter over a valid/ready interface. It caps the number of in-flight transactions and serialises non-cacheable loads behind all outstanding traffic. It counts returns to report idleness and protocol errors.

Parameters:
Depth, 4, FIFO entries; power of two, >=2
PlenWidth, 56, physical address width (riscv::PLEN)
TidWidth, 2, transaction ID width (CACHE_ID_WIDTH)
MaxOutstanding, 4, maximum issued-but-unreturned transactions; >=1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
req_vld_i  in  1  request from dcache; held until acked
req_ack_o  out  1  single-cycle accept pulse
req_type_i  in  2  0=LOAD 1=STORE 2=AMO; 3 reserved
req_nc_i  in  1  non-cacheable
req_size_i  in  3  log2 bytes
req_tid_i  in  TidWidth  transaction ID
req_paddr_i  in  PlenWidth  physical address
req_data_i  in  64  write/AMO data
out_vld_o  out  1  request to memory adapter
out_rdy_i  in  1  adapter ready
out_type_o / out_nc_o / out_size_o / out_tid_o / out_paddr_o / out_data_o  out  as inputs  head-entry fields
rtrn_vld_i  in  1  one return (any type) completed this cycle
idle_o  out  1  FIFO empty and nothing outstanding
err_o  out  1  sticky: return received with zero outstanding

Behaviour:
- Reset (rst_ni=0 at a clock edge): FIFO empty, pointers=0, outstanding count=0, err_o=0. Outputs during and after reset: req_ack_o=0, out_vld_o=0, idle_o=1. Reset mid-operation discards queued and in-flight bookkeeping. No async behaviour.
- Accept: req_ack_o = req_vld_i & ~full. full is the registered FIFO count == Depth. There is no same-cycle bypass from pop, so a full FIFO rejects even when it pops that cycle. The entry is written at that edge.
- Type 3 is accepted, forwarded unchanged, and counted like any other transaction.
- FIFO: circular buffer, wr/rd pointers log2(Depth) bits, wrap naturally. Count is log2(Depth)+1 bits. Push and pop in the same cycle leave the count unchanged.
- Latency: a request acked at edge t is visible on out_vld_o no earlier than the cycle after t (registered storage, minimum 1 cycle).
- Issue gate: out_vld_o = ~empty & (cnt < MaxOutstanding) & ~nc_block. nc_block = head is LOAD & nc & cnt != 0.
- out_* always show the head entry and stay stable while out_vld_o=1 and out_rdy_i=0. Handshake is out_vld_o & out_rdy_i, which pops the head and increments the count.
- out_vld_o must not drop without a handshake once asserted, except on reset. A gate condition may only change through a handshake, so this is guaranteed.
- Count update per edge: +1 on issue, -1 on rtrn_vld_i, net 0 if both occur together.
- A return with cnt==0 and no same-cycle issue: count stays 0 (saturates), err_o set until reset.
- A return together with an issue at cnt==0 is legal: count stays 0, no error.
- Count never exceeds MaxOutstanding.
- idle_o = empty & (cnt==0), registered-state derived (combinational from state only).
- Field widths pass through unmodified. No address or data manipulation.

Test Plan:
- Reset then single STORE, tid=1, paddr=0x80001000, data=0xDEADBEEF, out_rdy_i=1: req_ack_o pulses at t0, out_vld_o=1 at t0+1 with identical fields, idle_o=0. After one rtrn_vld_i, idle_o=1.
- Depth=4, out_rdy_i=0, 5 back-to-back requests: 4 acked, 5th held unacked. Raising out_rdy_i for 1 cycle pops one and the 5th is acked the following cycle. Check FIFO order across the pointer wrap.
- MaxOutstanding=4, out_rdy_i=1, 6 queued stores, no returns: exactly 4 issued, out_vld_o=0. One rtrn_vld_i leads to exactly one more issue the next cycle.
- Two cacheable loads issued, then NC load at head: out_vld_o=0 until both returned (cnt==0). It then issues. A cacheable store queued behind it waits.
- rtrn_vld_i with cnt=0 gives err_o=1 and stays 1. Simultaneous issue+return at cnt=2 leaves cnt at 2. Reset clears err_o.
- Reset asserted with 3 queued and 2 outstanding: next cycle idle_o=1, out_vld_o=0, and a new request is acked normally.
